rx_frame_collect: RTL and testbench

Receive-side frame collector for the host link of the matrix-vector unit. It consumes the byte stream delivered by the serial receiver as one-cycle strobes, and validates frames of the form START, four payload bytes, END. On a good frame it presents the four payload bytes in parallel with a one-cycle valid pulse, mirroring the four-byte result burst the transmit side emits. Malformed or stalled frames are discarded and flagged.

---
 rtl/rx_frame_collect.sv | 173 +++++++++++++++++
 tb/tb_rx_frame_collect.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_collect.sv
`timescale 1ns/1ps
// rx_frame_collect
// Collects START, four payload bytes, END frames from the host-link serial
// receiver. A good frame updates the four parallel payload outputs and pulses
// o_data_valid. A frame with a bad end byte or a stalled frame is discarded
// and o_frame_error pulses.
//
// State table
//   state      | meaning
//   S_IDLE     | waiting for START_BYTE; every other byte is ignored
//   S_PAYLOAD  | storing payload byte r_idx into the shadow buffer
//   S_WAIT_END | four bytes held in shadow; next byte must be END_BYTE
//
// Ports
//   i_clk          system clock, posedge
//   i_reset        synchronous active-high reset
//   i_rx_pulse     one-cycle strobe, i_rx_data is valid
//   i_rx_data      received byte
//   o_data1..4     payload bytes 0..3 of the last good frame
//   o_data_valid   one-cycle pulse, o_data1..4 just updated
//   o_frame_error  one-cycle pulse, frame discarded
//   o_busy         a frame is in progress
module rx_frame_collect #(
    parameter logic [7:0]  START_BYTE = 8'hFE,
    parameter logic [7:0]  END_BYTE   = 8'hEF,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned TMR_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_pulse,
    input  logic [7:0] i_rx_data,
    output logic [7:0] o_data1,
    output logic [7:0] o_data2,
    output logic [7:0] o_data3,
    output logic [7:0] o_data4,
    output logic       o_data_valid,
    output logic       o_frame_error,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PAYLOAD  = 2'd1,
        S_WAIT_END = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [1:0]         r_idx;
    logic [TMR_W-1:0]   r_timer;
    logic [7:0]         r_shadow [0:3];
    logic [7:0]         r_data   [0:3];
    logic               r_data_valid;
    logic               r_frame_error;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [1:0]         w_idx_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic               w_shadow_we;
    logic               w_commit;
    logic               w_error;
    logic               w_timeout;

    // A strobe in the last allowed cycle is accepted, so the timeout only
    // fires on a quiet cycle.
    assign w_timeout = !i_rx_pulse && (r_timer == TMR_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_shadow_we = 1'b0;
        w_commit    = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idx_nxt   = 2'd0;
                w_timer_nxt = '0;
                if (i_rx_pulse && (i_rx_data == START_BYTE)) begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (i_rx_pulse) begin
                    w_shadow_we = 1'b1;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_timer_nxt = '0;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_WAIT_END;
                    end
                end else if (w_timeout) begin
                    w_error     = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_WAIT_END: begin
                if (i_rx_pulse) begin
                    w_idx_nxt   = 2'd0;
                    w_timer_nxt = '0;
                    if (i_rx_data == END_BYTE) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (i_rx_data == START_BYTE) begin
                        // treat the stray START as the beginning of a new frame
                        w_error     = 1'b1;
                        w_state_nxt = S_PAYLOAD;
                    end else begin
                        w_error     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_error     = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_idx_nxt   = 2'd0;
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_timer       <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 8'h00;
                r_data[i]   <= 8'h00;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_data_valid  <= w_commit;
            r_frame_error <= w_error;
            r_busy        <= (w_state_nxt != S_IDLE);
            if (w_shadow_we) begin
                r_shadow[r_idx] <= i_rx_data;
            end
            if (w_commit) begin
                for (int i = 0; i < 4; i++) begin
                    r_data[i] <= r_shadow[i];
                end
            end
        end
    end

    assign o_data1       = r_data[0];
    assign o_data2       = r_data[1];
    assign o_data3       = r_data[2];
    assign o_data4       = r_data[3];
    assign o_data_valid  = r_data_valid;
    assign o_frame_error = r_frame_error;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_rx_frame_collect.sv
`timescale 1ns/1ps
// Directed bench for rx_frame_collect. Two instances share the stimulus:
// u_dut uses the default timeout, u_dut_t8 uses TIMEOUT=8 for stall cases.
module tb_rx_frame_collect;

    logic       clk;
    logic       reset;
    logic       rx_pulse;
    logic [7:0] rx_data;

    logic [7:0] d1, d2, d3, d4;
    logic       d_valid, d_err, d_busy;
    logic [7:0] t1, t2, t3, t4;
    logic       t_valid, t_err, t_busy;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int vld_cnt = 0, err_cnt = 0, both_cnt = 0;
    int vld_cyc = -1, err_cyc = -1;
    int t_vld_cnt = 0, t_err_cnt = 0, t_err_cyc = -1;

    rx_frame_collect u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_pulse   (rx_pulse),
        .i_rx_data    (rx_data),
        .o_data1      (d1),
        .o_data2      (d2),
        .o_data3      (d3),
        .o_data4      (d4),
        .o_data_valid (d_valid),
        .o_frame_error(d_err),
        .o_busy       (d_busy)
    );

    rx_frame_collect #(.TIMEOUT(8), .TMR_W(4)) u_dut_t8 (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_pulse   (rx_pulse),
        .i_rx_data    (rx_data),
        .o_data1      (t1),
        .o_data2      (t2),
        .o_data3      (t3),
        .o_data4      (t4),
        .o_data_valid (t_valid),
        .o_frame_error(t_err),
        .o_busy       (t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d_valid === 1'b1) begin
            vld_cnt = vld_cnt + 1;
            vld_cyc = cyc;
        end
        if (d_err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if ((d_valid === 1'b1 && d_err === 1'b1) || (t_valid === 1'b1 && t_err === 1'b1))
            both_cnt = both_cnt + 1;
        if (t_valid === 1'b1) t_vld_cnt = t_vld_cnt + 1;
        if (t_err === 1'b1) begin
            t_err_cnt = t_err_cnt + 1;
            t_err_cyc = cyc;
        end
    end

    // one call = one clock cycle of input
    task automatic drive(input logic p, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_pulse = p;
        rx_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    // consecutive strobes, first byte in the most significant position
    task automatic burst(input logic [87:0] bytes, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_pulse = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected %h", {d1, d2, d3, d4}, 32'h0);
        end
        n_tests++;
        if (d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", d_valid);
        end
        n_tests++;
        if (d_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", d_err);
        end
        n_tests++;
        if (d_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", d_busy);
        end
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_good_frame;
        logic [47:0] fr;
        int v0, e0, s;
        fr = 48'hFE11223344EF;
        v0 = vld_cnt;
        e0 = err_cnt;
        s = 0;
        drive(1'b1, 8'hFE);
        drive(1'b0, 8'h00);
        n_tests++;
        if (d_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL good_busy_high: got %b expected 1", d_busy);
        end
        idle(14);
        for (int i = 1; i < 6; i++) begin
            drive(1'b1, fr[8*(5-i) +: 8]);
            if (i == 5) s = cyc;
            else idle(15);
            if (i == 4) begin
                n_tests++;
                if ({d1, d2, d3, d4} !== 32'h0) begin
                    n_fail++;
                    $display("FAIL good_shadow_hidden: got %h expected %h", {d1, d2, d3, d4}, 32'h0);
                end
            end
        end
        idle(3);
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'h11223344) begin
            n_fail++;
            $display("FAIL good_data: got %h expected %h", {d1, d2, d3, d4}, 32'h11223344);
        end
        n_tests++;
        if (vld_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL good_valid_count: got %0d expected 1", vld_cnt - v0);
        end
        n_tests++;
        if (vld_cyc !== s + 1) begin
            n_fail++;
            $display("FAIL good_valid_latency: got cycle %0d expected %0d", vld_cyc, s + 1);
        end
        n_tests++;
        if (err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL good_no_error: got %0d expected 0", err_cnt - e0);
        end
        n_tests++;
        if (d_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_busy_low: got %b expected 0", d_busy);
        end
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        burst(88'hFEFEEF00FFEF, 6);
        idle(2);
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'hFEEF00FF) begin
            n_fail++;
            $display("FAIL b2b_data: got %h expected %h", {d1, d2, d3, d4}, 32'hFEEF00FF);
        end
        n_tests++;
        if (vld_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL b2b_valid_count: got %0d expected 1", vld_cnt - v0);
        end
        n_tests++;
        if (err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_no_error: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_bad_end;
        int v0, e0, s;
        burst(88'hFEAABBCCDDEF, 6);
        idle(2);
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL bad_end_setup: got %h expected %h", {d1, d2, d3, d4}, 32'hAABBCCDD);
        end
        v0 = vld_cnt;
        e0 = err_cnt;
        burst(88'hFE0102030455, 6);
        s = cyc;
        idle(3);
        n_tests++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL bad_end_err_count: got %0d expected 1", err_cnt - e0);
        end
        n_tests++;
        if (err_cyc !== s + 1) begin
            n_fail++;
            $display("FAIL bad_end_err_latency: got cycle %0d expected %0d", err_cyc, s + 1);
        end
        n_tests++;
        if (vld_cnt - v0 !== 0) begin
            n_fail++;
            $display("FAIL bad_end_no_valid: got %0d expected 0", vld_cnt - v0);
        end
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL bad_end_data_hold: got %h expected %h", {d1, d2, d3, d4}, 32'hAABBCCDD);
        end
        n_tests++;
        if (d_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_end_busy: got %b expected 0", d_busy);
        end
    endtask

    task automatic test_resync;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        burst(88'hFE01020304FE05060708EF, 11);
        idle(3);
        n_tests++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL resync_err_count: got %0d expected 1", err_cnt - e0);
        end
        n_tests++;
        if (vld_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL resync_valid_count: got %0d expected 1", vld_cnt - v0);
        end
        n_tests++;
        if (!(err_cyc < vld_cyc)) begin
            n_fail++;
            $display("FAIL resync_order: err cycle %0d valid cycle %0d, error must come first", err_cyc, vld_cyc);
        end
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'h05060708) begin
            n_fail++;
            $display("FAIL resync_data: got %h expected %h", {d1, d2, d3, d4}, 32'h05060708);
        end
    endtask

    task automatic test_timeout;
        int v0, e0, s;
        v0 = t_vld_cnt;
        e0 = t_err_cnt;
        drive(1'b1, 8'hFE);
        drive(1'b1, 8'h01);
        s = cyc;
        idle(12);
        n_tests++;
        if (t_err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_err_count: got %0d expected 1", t_err_cnt - e0);
        end
        n_tests++;
        if (t_err_cyc !== s + 9) begin
            n_fail++;
            $display("FAIL timeout_err_cycle: got cycle %0d expected %0d", t_err_cyc, s + 9);
        end
        n_tests++;
        if (t_vld_cnt - v0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_no_valid: got %0d expected 0", t_vld_cnt - v0);
        end
        n_tests++;
        if (t_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_busy: got %b expected 0", t_busy);
        end
    endtask

    // every strobe lands in the cycle where the timer holds TIMEOUT-1
    task automatic test_timeout_edge;
        logic [47:0] fr;
        int v0, e0;
        fr = 48'hFE01020304EF;
        v0 = t_vld_cnt;
        e0 = t_err_cnt;
        drive(1'b1, 8'hFE);
        drive(1'b1, 8'h01);
        for (int i = 2; i < 6; i++) begin
            idle(7);
            drive(1'b1, fr[8*(5-i) +: 8]);
        end
        idle(3);
        n_tests++;
        if (t_err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL tmo_edge_no_error: got %0d expected 0", t_err_cnt - e0);
        end
        n_tests++;
        if (t_vld_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL tmo_edge_valid_count: got %0d expected 1", t_vld_cnt - v0);
        end
        n_tests++;
        if ({t1, t2, t3, t4} !== 32'h01020304) begin
            n_fail++;
            $display("FAIL tmo_edge_data: got %h expected %h", {t1, t2, t3, t4}, 32'h01020304);
        end
    endtask

    task automatic test_reset_midframe;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        burst(88'hFE0102, 3);
        @(posedge clk);
        #1;
        rx_pulse = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_data: got %h expected %h", {d1, d2, d3, d4}, 32'h0);
        end
        n_tests++;
        if (d_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy: got %b expected 0", d_busy);
        end
        drive(1'b1, 8'h12);
        drive(1'b0, 8'h00);
        drive(1'b1, 8'hEF);
        drive(1'b0, 8'h00);
        drive(1'b1, 8'h55);
        idle(3);
        n_tests++;
        if ((vld_cnt - v0 !== 0) || (err_cnt - e0 !== 0) || (d_busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL idle_garbage: got valid %0d err %0d busy %b expected 0 0 0",
                     vld_cnt - v0, err_cnt - e0, d_busy);
        end
        burst(88'hFE090A0B0CEF, 6);
        idle(3);
        n_tests++;
        if ({d1, d2, d3, d4} !== 32'h090A0B0C) begin
            n_fail++;
            $display("FAIL midreset_frame_data: got %h expected %h", {d1, d2, d3, d4}, 32'h090A0B0C);
        end
        n_tests++;
        if (err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_error: got %0d expected 0", err_cnt - e0);
        end
        n_tests++;
        if (vld_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL midreset_valid_count: got %0d expected 1", vld_cnt - v0);
        end
    endtask

    task automatic test_exclusive;
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL valid_err_exclusive: got %0d overlapping cycles expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_back_to_back;
        test_bad_end;
        test_resync;
        test_timeout;
        test_timeout_edge;
        test_reset_midframe;
        test_exclusive;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
